// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - timing presets, totals and the packed pipeline tap for the video timing generator.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  function automatic int total_h(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int total_v(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // act/ls/fs/vb only ever occur in these six combinations, so three bits carry all four.
  typedef enum logic [2:0] {
    PX_HBLANK = 3'd0,
    PX_ACTIVE = 3'd1,
    PX_LINE   = 3'd2,
    PX_FRAME  = 3'd3,
    PX_VBLANK = 3'd4,
    PX_VBLINE = 3'd5
  } px_kind_e;

  typedef struct packed {
    logic     hs;
    logic     vs;
    px_kind_e kind;
  } tap_t;

  function automatic px_kind_e encode_kind(input logic act, input logic ls, input logic fs,
                                           input logic vb);
    px_kind_e k;
    k = PX_HBLANK;
    if (vb)       k = ls ? PX_VBLINE : PX_VBLANK;
    else if (fs)  k = PX_FRAME;
    else if (ls)  k = PX_LINE;
    else if (act) k = PX_ACTIVE;
    return k;
  endfunction

  function automatic logic kind_act(input px_kind_e k);
    return (k == PX_ACTIVE) || (k == PX_LINE) || (k == PX_FRAME);
  endfunction

  function automatic logic kind_ls(input px_kind_e k);
    return (k == PX_LINE) || (k == PX_FRAME) || (k == PX_VBLINE);
  endfunction

  function automatic logic kind_fs(input px_kind_e k);
    return k == PX_FRAME;
  endfunction

  function automatic logic kind_vb(input px_kind_e k);
    return (k == PX_VBLANK) || (k == PX_VBLINE);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - ce-gated shift register with synchronous clear to all-zero.
module vga_delay_line #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pclk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (ce) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with early coordinates and
// LATENCY-aligned sync, data-enable and event outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11,
  parameter int LATENCY  = 2,
  parameter int FRAME_W  = 16
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic               ce,
  output logic [CW-1:0]      x_early,
  output logic [CW-1:0]      y_early,
  output logic               act_early,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = total_h(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total_v(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] h;
  logic [CW-1:0] v;

  always_ff @(posedge pclk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + CNT_ONE;
      end else begin
        h <= h + CNT_ONE;
      end
    end
  end

  assign x_early   = h;
  assign y_early   = v;
  assign act_early = (h < H_ACT) && (v < V_ACT);

  logic hs_raw;
  logic vs_raw;
  logic ls_raw;
  logic fs_raw;
  logic vb_raw;
  tap_t tap_in;
  tap_t tap_out;

  always_comb begin
    hs_raw      = (h >= HS_BEG) && (h < HS_END);
    vs_raw      = (v >= VS_BEG) && (v < VS_END);
    ls_raw      = (h == '0);
    fs_raw      = ls_raw && (v == '0);
    vb_raw      = (v >= V_ACT);
    tap_in.hs   = hs_raw;
    tap_in.vs   = vs_raw;
    tap_in.kind = encode_kind(act_early, ls_raw, fs_raw, vb_raw);
  end

  vga_delay_line #(
    .WIDTH ($bits(tap_t)),
    .DEPTH (LATENCY)
  ) u_delay (
    .pclk  (pclk),
    .reset (reset),
    .ce    (ce),
    .din   (tap_in),
    .dout  (tap_out)
  );

  // Reset also masks the outputs combinationally so the reset cycle itself is already quiet.
  assign hsync       = reset ? ~HS_POL : ~(tap_out.hs ^ HS_POL);
  assign vsync       = reset ? ~VS_POL : ~(tap_out.vs ^ VS_POL);
  assign de          = ~reset & kind_act(tap_out.kind);
  assign vblank      = ~reset & kind_vb(tap_out.kind);
  assign line_start  = ~reset & ce & kind_ls(tap_out.kind);
  assign frame_start = ~reset & ce & kind_fs(tap_out.kind);

  always_ff @(posedge pclk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen across three timing configurations.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int M_VA = 4, M_VF = 1, M_VS = 2, M_VB = 1, M_LAT = 8, M_FW = 8;
  localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
  localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1, S_LAT = 1, S_FW = 2;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
    int lat, fw;
  } cfg_t;

  typedef struct {
    bit hs, vs, act, ls, fs, vb;
  } raw_t;

  typedef struct {
    int x, y;
    bit act, hs, vs, de, ls, fs, vb;
    int fc;
  } exp_t;

  function automatic cfg_t cfg_of(input int i);
    cfg_t c;
    c = '{ha: VGA640_H_ACTIVE, hf: VGA640_H_FP, hs: VGA640_H_SYNC, hb: VGA640_H_BP,
          va: VGA640_V_ACTIVE, vf: VGA640_V_FP, vs: VGA640_V_SYNC, vb: VGA640_V_BP,
          hp: 1'b0, vp: 1'b0, lat: 2, fw: 16};
    if (i == 1) begin
      c.va = M_VA; c.vf = M_VF; c.vs = M_VS; c.vb = M_VB;
      c.hp = 1'b0; c.vp = 1'b1; c.lat = M_LAT; c.fw = M_FW;
    end else if (i == 2) begin
      c = '{ha: S_HA, hf: S_HF, hs: S_HS, hb: S_HB, va: S_VA, vf: S_VF, vs: S_VS, vb: S_VB,
            hp: 1'b1, vp: 1'b1, lat: S_LAT, fw: S_FW};
    end
    return c;
  endfunction

  function automatic raw_t raw_of(input cfg_t c, input int h, input int v);
    raw_t r;
    r.hs  = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs);
    r.vs  = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vs);
    r.act = (h < c.ha) && (v < c.va);
    r.ls  = (h == 0);
    r.fs  = (h == 0) && (v == 0);
    r.vb  = (v >= c.va);
    return r;
  endfunction

  logic pclk = 1'b0;
  logic reset;
  logic ce;
  always #5 pclk = ~pclk;

  logic [10:0] x0, y0, x1, y1;
  logic [3:0]  x2, y2;
  logic        act0, hs0, vs0, de0, ls0, fs0, vb0;
  logic        act1, hs1, vs1, de1, ls1, fs1, vb1;
  logic        act2, hs2, vs2, de2, ls2, fs2, vb2;
  logic [15:0] fc0;
  logic [7:0]  fc1;
  logic [1:0]  fc2;

  vga_timing_gen u_def (
    .pclk(pclk), .reset(reset), .ce(ce), .x_early(x0), .y_early(y0), .act_early(act0),
    .hsync(hs0), .vsync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0), .vblank(vb0),
    .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .V_ACTIVE(M_VA), .V_FP(M_VF), .V_SYNC(M_VS), .V_BP(M_VB), .HS_POL(1'b0), .VS_POL(1'b1),
    .CW(11), .LATENCY(M_LAT), .FRAME_W(M_FW)
  ) u_med (
    .pclk(pclk), .reset(reset), .ce(ce), .x_early(x1), .y_early(y1), .act_early(act1),
    .hsync(hs1), .vsync(vs1), .de(de1), .line_start(ls1), .frame_start(fs1), .vblank(vb1),
    .frame_cnt(fc1)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .HS_POL(1'b1), .VS_POL(1'b1),
    .CW(4), .LATENCY(S_LAT), .FRAME_W(S_FW)
  ) u_small (
    .pclk(pclk), .reset(reset), .ce(ce), .x_early(x2), .y_early(y2), .act_early(act2),
    .hsync(hs2), .vsync(vs2), .de(de2), .line_start(ls2), .frame_start(fs2), .vblank(vb2),
    .frame_cnt(fc2)
  );

  exp_t obs [3];
  always_comb begin
    obs[0] = '{x: int'(x0), y: int'(y0), act: act0, hs: hs0, vs: vs0, de: de0, ls: ls0,
               fs: fs0, vb: vb0, fc: int'(fc0)};
    obs[1] = '{x: int'(x1), y: int'(y1), act: act1, hs: hs1, vs: vs1, de: de1, ls: ls1,
               fs: fs1, vb: vb1, fc: int'(fc1)};
    obs[2] = '{x: int'(x2), y: int'(y2), act: act2, hs: hs2, vs: vs2, de: de2, ls: ls2,
               fs: fs2, vb: vb2, fc: int'(fc2)};
  end

  // Reference model: position per instance plus a queue of the raw terms of recent ce states.
  int   mh [3];
  int   mv [3];
  int   mfc [3];
  raw_t hist [3][$];
  exp_t expq [3][$];

  bit done;
  bit seek_miss;
  int phase;

  task automatic step(input bit c_in, input bit r_in);
    bit   dfs [3];
    cfg_t c;
    raw_t d;
    exp_t e;
    ce    = c_in;
    reset = r_in;
    for (int i = 0; i < 3; i++) begin
      c = cfg_of(i);
      d = '{default: 1'b0};
      if (hist[i].size() == c.lat) d = hist[i][c.lat-1];
      e.x   = mh[i];
      e.y   = mv[i];
      e.act = raw_of(c, mh[i], mv[i]).act;
      e.fc  = mfc[i];
      if (r_in) begin
        e.hs = !c.hp; e.vs = !c.vp; e.de = 0; e.ls = 0; e.fs = 0; e.vb = 0;
      end else begin
        e.hs = d.hs ? c.hp : !c.hp;
        e.vs = d.vs ? c.vp : !c.vp;
        e.de = d.act;
        e.ls = d.ls && c_in;
        e.fs = d.fs && c_in;
        e.vb = d.vb;
      end
      dfs[i] = e.fs;
      expq[i].push_back(e);
    end
    @(posedge pclk);
    for (int i = 0; i < 3; i++) begin
      c = cfg_of(i);
      if (r_in) begin
        mh[i] = 0; mv[i] = 0; mfc[i] = 0;
        hist[i].delete();
      end else if (c_in) begin
        if (dfs[i]) mfc[i] = (mfc[i] + 1) % (1 << c.fw);
        hist[i].push_front(raw_of(c, mh[i], mv[i]));
        if (hist[i].size() > c.lat) void'(hist[i].pop_back());
        mh[i]++;
        if (mh[i] == total_h(c.ha, c.hf, c.hs, c.hb)) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == total_v(c.va, c.vf, c.vs, c.vb)) mv[i] = 0;
        end
      end
    end
    #1;
  endtask

  initial begin
    int k;
    ce = 1'b1; reset = 1'b1; done = 0; seek_miss = 0; phase = 0;
    for (int i = 0; i < 3; i++) begin mh[i] = 0; mv[i] = 0; mfc[i] = 0; end
    @(posedge pclk);
    #1;
    phase = 1;
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1);
    for (int n = 0; n < 14000; n++) step(1'b1, 1'b0);
    phase = 2;
    for (int n = 0; n < 3300; n++) step(bit'(n % 3 == 0), 1'b0);
    phase = 3;
    for (int n = 0; n < 8000; n++)
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1999) == 0));
    phase = 4;
    k = 0;
    while (!(mh[2] == 11 && mv[2] == 5) && k < 400) begin
      step(1'b1, 1'b0);
      k++;
    end
    if (k >= 400) seek_miss = 1;
    step(1'b1, 1'b1);
    for (int n = 0; n < 1500; n++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int n = 0; n < 1500; n++) step(bit'($urandom_range(0, 3) != 0), 1'b0);
    done = 1;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = 0;
  int last_fs_phase = 0;
  int period_seen = 0;
  bit de_valid = 0;
  int de_cnt = 0;
  int de_frames = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge pclk) begin
    exp_t e;
    exp_t o;
    cyc++;
    if (done) begin
      for (int i = 0; i < 3; i++) chk($sformatf("u%0d.queue_left", i), expq[i].size(), 0);
      chk("seek_h11_v5", int'(seek_miss), 0);
      chk("u2.period_checked", int'(period_seen >= 5), 1);
      chk("u1.de_frames_checked", int'(de_frames >= 2), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (expq[i].size() > 0) begin
          e = expq[i].pop_front();
          o = obs[i];
          chk($sformatf("u%0d.x_early", i), o.x, e.x);
          chk($sformatf("u%0d.y_early", i), o.y, e.y);
          chk($sformatf("u%0d.act_early", i), int'(o.act), int'(e.act));
          chk($sformatf("u%0d.hsync", i), int'(o.hs), int'(e.hs));
          chk($sformatf("u%0d.vsync", i), int'(o.vs), int'(e.vs));
          chk($sformatf("u%0d.de", i), int'(o.de), int'(e.de));
          chk($sformatf("u%0d.line_start", i), int'(o.ls), int'(e.ls));
          chk($sformatf("u%0d.frame_start", i), int'(o.fs), int'(e.fs));
          chk($sformatf("u%0d.vblank", i), int'(o.vb), int'(e.vb));
          chk($sformatf("u%0d.frame_cnt", i), o.fc, e.fc);
        end
      end
      if (obs[2].fs) begin
        if (phase == 2 && last_fs_phase == 2) begin
          chk("u2.frame_period_ce_every_3rd", cyc - last_fs,
              3 * total_h(S_HA, S_HF, S_HS, S_HB) * total_v(S_VA, S_VF, S_VS, S_VB));
          period_seen++;
        end
        last_fs = cyc;
        last_fs_phase = phase;
      end
      if (reset) begin
        de_valid = 0;
        de_cnt = 0;
      end else begin
        if (obs[1].fs) begin
          if (de_valid) begin
            chk("u1.de_cycles_per_frame", de_cnt, VGA640_H_ACTIVE * M_VA);
            de_frames++;
          end
          de_valid = 1;
          de_cnt = 0;
        end
        if (ce && obs[1].de) de_cnt++;
      end
    end
  end

endmodule
